// File: rtl/sm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm_mem_arbiter
// Purpose  : Round-robin arbiter sharing one single-ported data memory among
//            N_SM requesters. Build macro SM_ARB_FIXED_PRIO_EN selects fixed
//            lowest-index priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module sm_mem_arbiter #(
  parameter int N_SM   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SM-1:0]          req,
  input  logic [N_SM-1:0]          req_we,
  input  logic [N_SM*ADDR_W-1:0]   req_addr,
  input  logic [N_SM*DATA_W-1:0]   req_wdata,
  output logic [N_SM-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy
);

  localparam int c_SEL_W = $clog2(N_SM);
  localparam int c_LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [c_SEL_W-1:0] c_LAST_SM  = c_SEL_W'(N_SM - 1);
  localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_SEL_W-1:0]   r_sel;
  logic [c_SEL_W-1:0]   w_ptr;
  logic [c_SEL_W-1:0]   w_pick;
  logic [c_LAT_W-1:0]   r_lat_cnt;
  logic                 r_is_write;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [DATA_W-1:0]    r_rdata;
  logic [ADDR_W-1:0]    w_addr  [N_SM];
  logic [DATA_W-1:0]    w_wdata [N_SM];

  generate
    for (genvar k = 0; k < N_SM; k++) begin : g_unpack
      assign w_addr[k]  = req_addr[k*ADDR_W +: ADDR_W];
      assign w_wdata[k] = req_wdata[k*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef SM_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [c_SEL_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (r_state == ST_DONE) begin
      r_ptr <= (r_sel == c_LAST_SM) ? '0 : r_sel + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    int idx;
    idx    = 0;
    w_pick = w_ptr;
    for (int i = N_SM - 1; i >= 0; i--) begin
      idx = int'(w_ptr) + i;
      if (idx >= N_SM) idx = idx - N_SM;
      if (req[idx]) w_pick = idx[c_SEL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (|req) w_state_next = ST_ACCESS;
      ST_ACCESS: if (r_is_write || (r_lat_cnt == '0)) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel       <= '0;
      r_lat_cnt   <= '0;
      r_is_write  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (|req)) begin
        r_sel       <= w_pick;
        r_mem_addr  <= w_addr[w_pick];
        r_mem_wdata <= w_wdata[w_pick];
        r_is_write  <= req_we[w_pick];
        r_lat_cnt   <= c_LAT_INIT;
      end else if ((r_state == ST_ACCESS) && !r_is_write) begin
        if (r_lat_cnt == '0) r_rdata   <= mem_rdata;
        else                 r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (r_state == ST_DONE) ack[r_sel] = 1'b1;
  end

  assign mem_we    = (r_state == ST_ACCESS) && r_is_write;
  assign busy      = (r_state != ST_IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;

endmodule
`default_nettype wire
